qoi_framer: RTL
===============

QOI_FRAMER -- requirements
Module: qoi_framer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: cs  in  1, we  in  1, addr  in  3 (addr_t), data_i  in  8 (byte_t), data_o  out  8 (byte_t); 6502 register bus.
REQ-004 SHALL have ports: enc_valid  in  1, enc_data  in  8, enc_last  in  1, enc_ready  out  1; encoded-byte stream from the encoder.
REQ-005 SHALL have ports: out_valid  out  1, out_data  out  8, out_ready  in  1; framed QOI file byte stream.
REQ-006 SHALL map registers: 0 ctrl (W: bit7 start, bit0 channels 0=3/1=4, bit1 colorspace); 1 status (R: bit7 busy, bit6 done); 2-3 width LE; 4-5 height LE; 6-7 body byte count LE (R).

Function
REQ-007 SHALL implement states IDLE, HDR, BODY, TAIL, DONE (framer_state_t).
REQ-008 SHALL latch width, height, channels and colorspace only in IDLE or DONE; writes in other states are ignored.
REQ-009 SHALL leave IDLE or DONE for HDR on a write of ctrl with bit7=1; start in any other state is ignored.
REQ-010 SHALL emit 14 header bytes in HDR: 0x71 0x6F 0x69 0x66, width as 32-bit big-endian (upper 16 bits 0), height as 32-bit big-endian, channels (3 or 4), colorspace (0 or 1).
REQ-011 SHALL go HDR -> BODY after header byte 13 is accepted, or HDR -> TAIL if width==0 or height==0.
REQ-012 SHALL, in BODY, assert enc_ready = (!out_valid || out_ready) and load the accepted enc_data into the output register, with 1-cycle latency.
REQ-013 SHALL go BODY -> TAIL when a byte with enc_last=1 is accepted.
REQ-014 SHALL emit 8 tail bytes in TAIL (0x00 x7, 0x01), then enter DONE after the final byte is accepted.
REQ-015 SHALL hold enc_ready=0 outside BODY; enc_valid outside BODY is ignored.
REQ-016 SHALL keep out_data stable and out_valid high while out_ready=0; a byte is consumed only on out_valid && out_ready.
REQ-017 SHALL increment a 16-bit body counter per accepted enc byte, wrapping at 0xFFFF, and clear it on start.
REQ-018 SHALL drive status busy=1 in HDR, BODY and TAIL, and done=1 in DONE only.
REQ-019 SHALL return data_o for the addressed register combinationally; reserved bits read 0.
REQ-020 SHALL sustain 1 byte per cycle throughput when out_ready is held high.

Reset
REQ-021 SHALL, on rst low, immediately force state=IDLE, out_valid=0, out_data=0x00, enc_ready=0, body count=0, all config registers=0, busy=0 and done=0.
REQ-022 SHALL discard any partially emitted frame on reset mid-operation; no byte is emitted until the next start.

Structure
REQ-023 SHALL place framer_state_t, QOI_MAGIC (32'h716F6966), HDR_LEN=14 and TAIL_LEN=8 in qoi_types, alongside byte_t and addr_t.
REQ-024 SHALL be implemented as a single module with one 4-bit phase counter shared by HDR and TAIL; no sub-module.

Verification
REQ-025 SHALL verify normal frame: width=2, height=1, ch=4, cs=0, body bytes 0xFE,0x10,0x20,0x30,0xC0(last), out_ready=1 -> stream 71 6F 69 66 00 00 00 02 00 00 00 01 04 00 FE 10 20 30 C0 00x7 01; count=5; done=1.
REQ-026 SHALL verify backpressure: out_ready toggled 1/0 each cycle during BODY -> out_data stable whenever stalled, enc_ready=0 while stalled, no byte lost or duplicated.
REQ-027 SHALL verify empty image: width=0 -> 14 header bytes, then 8 tail bytes; enc_ready never asserted; count=0.
REQ-028 SHALL verify ignored writes: start and width writes during BODY -> no restart; header width unchanged; busy remains 1.
REQ-029 SHALL verify reset mid-operation: rst low at header byte 7 -> out_valid=0 in the same cycle and state=IDLE; a restart emits a full header from 0x71.
REQ-030 SHALL verify counter wrap: 65537 body bytes -> count reads 0x0001 and the tail follows correctly.

Source files
------------

// File: rtl/qoi_types.sv
// Shared types, constants and header-byte helper for the QOI framer.
package qoi_types;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned PHASE_W  = 4;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned DIM_W    = 16;
    localparam int unsigned HDR_LEN  = 14;
    localparam int unsigned TAIL_LEN = 8;

    localparam logic [31:0] QOI_MAGIC = 32'h716F6966;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        BODY,
        TAIL,
        DONE
    } framer_state_t;

    localparam addr_t REG_CTRL   = 3'd0;
    localparam addr_t REG_STATUS = 3'd1;
    localparam addr_t REG_W_LO   = 3'd2;
    localparam addr_t REG_W_HI   = 3'd3;
    localparam addr_t REG_H_LO   = 3'd4;
    localparam addr_t REG_H_HI   = 3'd5;
    localparam addr_t REG_CNT_LO = 3'd6;
    localparam addr_t REG_CNT_HI = 3'd7;

    // Header byte at position idx: magic, 32-bit BE width/height (upper half zero), channels, colorspace.
    function automatic byte_t hdr_byte(input logic [PHASE_W-1:0] idx,
                                       input logic [DIM_W-1:0]   w,
                                       input logic [DIM_W-1:0]   h,
                                       input logic               ch4,
                                       input logic               cspace);
        byte_t b;
        case (idx)
            4'd0:    b = QOI_MAGIC[31:24];
            4'd1:    b = QOI_MAGIC[23:16];
            4'd2:    b = QOI_MAGIC[15:8];
            4'd3:    b = QOI_MAGIC[7:0];
            4'd6:    b = w[15:8];
            4'd7:    b = w[7:0];
            4'd10:   b = h[15:8];
            4'd11:   b = h[7:0];
            4'd12:   b = ch4 ? 8'd4 : 8'd3;
            4'd13:   b = {7'd0, cspace};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/qoi_framer.sv
// Wraps an encoded QOI byte stream with the 14-byte header and 8-byte end marker.
module qoi_framer
    import qoi_types::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  cs,
    input  logic  we,
    input  addr_t addr,
    input  byte_t data_i,
    output byte_t data_o,
    input  logic  enc_valid,
    input  byte_t enc_data,
    input  logic  enc_last,
    output logic  enc_ready,
    output logic  out_valid,
    output byte_t out_data,
    input  logic  out_ready
);

    framer_state_t      state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               out_valid_q, out_valid_d;
    byte_t              out_data_q, out_data_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DIM_W-1:0]   width_q, width_d;
    logic [DIM_W-1:0]   height_q, height_d;
    logic               ch4_q, ch4_d;
    logic               cspace_q, cspace_d;

    logic out_free_c;
    logic accept_out_c;
    logic wr_c;
    logic busy_c;
    logic done_c;
    logic empty_c;

    assign out_free_c   = !out_valid_q || out_ready;
    assign accept_out_c = out_valid_q && out_ready;
    assign wr_c         = cs && we;
    assign busy_c       = (state_q == HDR) || (state_q == BODY) || (state_q == TAIL);
    assign done_c       = (state_q == DONE);
    assign empty_c      = (width_q == '0) || (height_q == '0);

    assign enc_ready = (state_q == BODY) && out_free_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // State, output register, counter and config registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            count_q     <= '0;
            width_q     <= '0;
            height_q    <= '0;
            ch4_q       <= 1'b0;
            cspace_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            count_q     <= count_d;
            width_q     <= width_d;
            height_q    <= height_d;
            ch4_q       <= ch4_d;
            cspace_q    <= cspace_d;
        end
    end

    // Next-state: config/start in IDLE/DONE, header, body pass-through, tail.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        count_d     = count_q;
        width_d     = width_q;
        height_d    = height_q;
        ch4_d       = ch4_q;
        cspace_d    = cspace_q;

        if (accept_out_c) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE, DONE: begin
                if (wr_c) begin
                    case (addr)
                        REG_CTRL: begin
                            ch4_d    = data_i[0];
                            cspace_d = data_i[1];
                            if (data_i[7]) begin
                                state_d = HDR;
                                phase_d = '0;
                                count_d = '0;
                            end
                        end
                        REG_W_LO: width_d[7:0]   = data_i;
                        REG_W_HI: width_d[15:8]  = data_i;
                        REG_H_LO: height_d[7:0]  = data_i;
                        REG_H_HI: height_d[15:8] = data_i;
                        default: ;
                    endcase
                end
            end
            HDR: begin
                if (phase_q < PHASE_W'(HDR_LEN)) begin
                    if (out_free_c) begin
                        out_valid_d = 1'b1;
                        out_data_d  = hdr_byte(phase_q, width_q, height_q, ch4_q, cspace_q);
                        phase_d     = phase_q + PHASE_W'(1);
                    end
                end else if (accept_out_c) begin
                    // Last header byte leaves; skip the body for a zero-area image.
                    phase_d = '0;
                    state_d = empty_c ? TAIL : BODY;
                end
            end
            BODY: begin
                if (enc_valid && out_free_c) begin
                    out_valid_d = 1'b1;
                    out_data_d  = enc_data;
                    count_d     = count_q + CNT_W'(1);
                    if (enc_last) begin
                        state_d = TAIL;
                        phase_d = '0;
                    end
                end
            end
            TAIL: begin
                if (phase_q < PHASE_W'(TAIL_LEN)) begin
                    if (out_free_c) begin
                        out_valid_d = 1'b1;
                        out_data_d  = (phase_q == PHASE_W'(TAIL_LEN - 1)) ? 8'h01 : 8'h00;
                        phase_d     = phase_q + PHASE_W'(1);
                    end
                end else if (accept_out_c) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register read mux.
    always_comb begin
        data_o = '0;
        case (addr)
            REG_CTRL:   data_o = {6'd0, cspace_q, ch4_q};
            REG_STATUS: data_o = {busy_c, done_c, 6'd0};
            REG_W_LO:   data_o = width_q[7:0];
            REG_W_HI:   data_o = width_q[15:8];
            REG_H_LO:   data_o = height_q[7:0];
            REG_H_HI:   data_o = height_q[15:8];
            REG_CNT_LO: data_o = count_q[7:0];
            REG_CNT_HI: data_o = count_q[15:8];
            default:    data_o = '0;
        endcase
    end

endmodule
